// File: rtl/sr_pulse_gen_pkg.sv
// sr_pulse_gen shared definitions: FSM state type, default timing
// constants and a counter-width helper used by all sr_pulse_gen files.
package sr_pulse_gen_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_PULSE_CYCLES    = 2;
   localparam int DEF_GAP_CYCLES      = 2;

   typedef enum logic [1:0] {
      IDLE,
      SET_PULSE,
      RST_PULSE,
      GAP
   } state_t;

   // A counter that must reach n-1 needs $clog2(n) bits, but never 0.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sr_pulse_gen_if.sv
// sr_pulse_gen user-side bundle: raw set/reset requests in, active-low
// latch drives and busy out. master = requester, slave = pulse generator.
interface sr_pulse_gen_if;

   logic set_in;
   logic reset_in;
   logic Sbar;
   logic Rbar;
   logic busy;

   modport master (
      output set_in,
      output reset_in,
      input  Sbar,
      input  Rbar,
      input  busy
   );

   modport slave (
      input  set_in,
      input  reset_in,
      output Sbar,
      output Rbar,
      output busy
   );

endinterface

// File: rtl/sr_debounce.sv
// One-input conditioner: 2-flop synchronizer, stable level and counter.
// Ports: clk, rstbar (async low), raw (async input), rise (1-cycle 0->1 strobe).
module sr_debounce
   import sr_pulse_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rstbar,
   input  logic raw,
   output logic rise
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          flip;

   // The edge that would take the count to DEBOUNCE_CYCLES flips the
   // level instead, so the counter never holds more than LAST.
   assign differ = sync[1] ^ stable;
   assign flip   = differ && (cnt == LAST);
   assign rise   = flip && sync[1];

   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) begin
         sync   <= '0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (!differ || flip)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (flip)
            stable <= sync[1];
      end
   end

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced push-button to NAND SR latch driver: turns set/reset presses
// into non-overlapping registered active-low pulses on Sbar / Rbar.
// Ports: clk, rstbar (async low), bus (sr_pulse_gen_if.slave:
// set_in, reset_in in; Sbar, Rbar, busy out).
// Option: SR_PULSE_GEN_TRACK_EN adds q_track and drops redundant events.
module sr_pulse_gen
   import sr_pulse_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
   input  logic           clk,
   input  logic           rstbar,
   sr_pulse_gen_if.slave  bus
);

   localparam int PW = cnt_w(PULSE_CYCLES);
   localparam int GW = cnt_w(GAP_CYCLES);
   localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);
   localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

   logic          set_rise;
   logic          rst_rise;
   logic          set_pend;
   logic          rst_pend;
   state_t        state;
   state_t        state_nxt;
   state_t        pick;
   logic [PW-1:0] pulse_cnt;
   logic [GW-1:0] gap_cnt;
   logic          pulse_done;
   logic          gap_done;
   logic          dispatch;
   logic          set_ok;
   logic          rst_ok;
   logic          set_drop;
   logic          rst_drop;
   logic          set_enter;
   logic          rst_enter;
   logic          sbar_q;
   logic          rbar_q;

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_set (
      .clk    (clk),
      .rstbar (rstbar),
      .raw    (bus.set_in),
      .rise   (set_rise)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_rst (
      .clk    (clk),
      .rstbar (rstbar),
      .raw    (bus.reset_in),
      .rise   (rst_rise)
   );

`ifdef SR_PULSE_GEN_TRACK_EN
   logic q_track;

   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar)
         q_track <= 1'b0;
      else if (set_enter)
         q_track <= 1'b1;
      else if (rst_enter)
         q_track <= 1'b0;
   end

   // An event that would drive the latch to the level it already
   // holds is redundant and is discarded at dispatch.
   always_comb begin
      set_ok   = set_pend && !q_track;
      rst_ok   = rst_pend &&  q_track;
      set_drop = set_pend &&  q_track;
      rst_drop = rst_pend && !q_track;
   end
`else
   always_comb begin
      set_ok   = set_pend;
      rst_ok   = rst_pend;
      set_drop = 1'b0;
      rst_drop = 1'b0;
   end
`endif

   assign pulse_done = (pulse_cnt == PLAST);
   assign gap_done   = (gap_cnt == GLAST);

   // The end of GAP dispatches like IDLE, so a queued event follows
   // after exactly GAP_CYCLES idle-high cycles.
   assign dispatch = (state == IDLE) || ((state == GAP) && gap_done);

   always_comb begin
      pick = IDLE;
      if (rst_ok)
         pick = RST_PULSE;
      else if (set_ok)
         pick = SET_PULSE;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      state_nxt = pick;
         SET_PULSE: if (pulse_done) state_nxt = GAP;
         RST_PULSE: if (pulse_done) state_nxt = GAP;
         GAP:       if (gap_done)   state_nxt = pick;
         default:   state_nxt = IDLE;
      endcase
   end

   assign set_enter = (state_nxt == SET_PULSE) && (state != SET_PULSE);
   assign rst_enter = (state_nxt == RST_PULSE) && (state != RST_PULSE);

   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         gap_cnt   <= '0;
         set_pend  <= 1'b0;
         rst_pend  <= 1'b0;
         sbar_q    <= 1'b1;
         rbar_q    <= 1'b1;
      end else begin
         state <= state_nxt;

         if (((state == SET_PULSE) || (state == RST_PULSE)) && !pulse_done)
            pulse_cnt <= pulse_cnt + 1'b1;
         else
            pulse_cnt <= '0;

         if ((state == GAP) && !gap_done)
            gap_cnt <= gap_cnt + 1'b1;
         else
            gap_cnt <= '0;

         // A new rise always wins over a same-cycle clear.
         set_pend <= set_rise ||
                     (set_pend && !set_enter && !(dispatch && set_drop));
         rst_pend <= rst_rise ||
                     (rst_pend && !rst_enter && !(dispatch && rst_drop));

         // Both drives decode one next-state value, so they can
         // never be low together.
         sbar_q <= (state_nxt != SET_PULSE);
         rbar_q <= (state_nxt != RST_PULSE);
      end
   end

   assign bus.Sbar = sbar_q;
   assign bus.Rbar = rbar_q;
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen with DEBOUNCE=4, PULSE=2, GAP=2.
// Expected pulses are queued with stimulus and compared against monitored pulses.
module tb_sr_pulse_gen;

   typedef struct packed {
      logic kind;
      int   start;
      int   width;
   } pulse_t;

   logic clk = 1'b0;
   logic rstbar = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   conflicts = 0;
   pulse_t exp_q[$];
   pulse_t obs_q[$];
   logic s_prev = 1'b1;
   logic r_prev = 1'b1;
   int   s_start = 0;
   int   r_start = 0;

   sr_pulse_gen_if bus ();

   sr_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .PULSE_CYCLES    (2),
      .GAP_CYCLES      (2)
   ) dut (
      .clk    (clk),
      .rstbar (rstbar),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: start = cyc at the first negedge seeing 0.
   always @(negedge clk) begin
      if (!bus.Sbar && s_prev) s_start = cyc;
      if (bus.Sbar && !s_prev)
         obs_q.push_back('{kind: 1'b0, start: s_start, width: cyc - s_start});
      if (!bus.Rbar && r_prev) r_start = cyc;
      if (bus.Rbar && !r_prev)
         obs_q.push_back('{kind: 1'b1, start: r_start, width: cyc - r_start});
      if (!bus.Sbar && !bus.Rbar) conflicts++;
      s_prev = bus.Sbar;
      r_prev = bus.Rbar;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.set_in = 1'b0;
      bus.reset_in = 1'b0;
      rstbar = 1'b0;
      wait_cyc(3);
      rstbar = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_reset();
      pulse_t e, o;
      bus.set_in = 1'b1;
      bus.reset_in = 1'b1;
      rstbar = 1'b0;
      wait_cyc(12);
      total++;
      if (bus.Sbar !== 1'b1) begin
         bad++; $display("FAIL reset_sbar got %b want 1", bus.Sbar);
      end
      total++;
      if (bus.Rbar !== 1'b1) begin
         bad++; $display("FAIL reset_rbar got %b want 1", bus.Rbar);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      bus.set_in = 1'b0;
      bus.reset_in = 1'b0;
      rstbar = 1'b1;
      wait_cyc(20);
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL reset_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_clean();
      int k;
      pulse_t e, o;
      do_reset();
      k = cyc;
      bus.set_in = 1'b1;
      exp_q.push_back('{kind: 1'b0, start: k + 7, width: 2});
      wait_cyc(7);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL clean_busy got %b want 1", bus.busy);
      end
      wait_cyc(20);
      bus.set_in = 1'b0;
      wait_cyc(15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL clean_pulse got none want k=%0d s=%0d w=%0d", e.kind, e.start, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++; $display("FAIL clean_pulse got k=%0d s=%0d w=%0d want k=%0d s=%0d w=%0d", o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL clean_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 40; i++) begin
         bus.set_in = (i % 4) != 3;
         wait_cyc(1);
      end
      bus.set_in = 1'b0;
      wait_cyc(20);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL bounce_busy got %b want 0", bus.busy);
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL bounce_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_both();
      int k;
      pulse_t e, o;
      conflicts = 0;
      k = cyc;
      bus.set_in = 1'b1;
      bus.reset_in = 1'b1;
      exp_q.push_back('{kind: 1'b1, start: k + 7, width: 2});
      exp_q.push_back('{kind: 1'b0, start: k + 11, width: 2});
      wait_cyc(12);
      bus.set_in = 1'b0;
      bus.reset_in = 1'b0;
      wait_cyc(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL both_pulse got none want k=%0d s=%0d w=%0d", e.kind, e.start, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++; $display("FAIL both_pulse got k=%0d s=%0d w=%0d want k=%0d s=%0d w=%0d", o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL both_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
      total++;
      if (conflicts != 0) begin
         bad++; $display("FAIL both_overlap got %0d conflicts want 0", conflicts);
      end
   endtask

   task automatic test_midpulse_reset();
      int k;
      pulse_t e, o;
      do_reset();
      k = cyc;
      bus.set_in = 1'b1;
      exp_q.push_back('{kind: 1'b0, start: k + 7, width: 1});
      wait_cyc(7);
      @(posedge clk);
      #2;
      rstbar = 1'b0;
      bus.set_in = 1'b0;
      #1;
      total++;
      if (bus.Sbar !== 1'b1) begin
         bad++; $display("FAIL mid_sbar got %b want 1", bus.Sbar);
      end
      total++;
      if (bus.Rbar !== 1'b1) begin
         bad++; $display("FAIL mid_rbar got %b want 1", bus.Rbar);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL mid_busy got %b want 0", bus.busy);
      end
      wait_cyc(3);
      rstbar = 1'b1;
      wait_cyc(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL mid_pulse got none want k=%0d s=%0d w=%0d", e.kind, e.start, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++; $display("FAIL mid_pulse got k=%0d s=%0d w=%0d want k=%0d s=%0d w=%0d", o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL mid_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_held_through_reset();
      int k;
      pulse_t e, o;
      @(negedge clk);
      bus.set_in = 1'b1;
      rstbar = 1'b0;
      wait_cyc(3);
      k = cyc;
      rstbar = 1'b1;
      exp_q.push_back('{kind: 1'b0, start: k + 7, width: 2});
      wait_cyc(15);
      bus.set_in = 1'b0;
      wait_cyc(15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL held_pulse got none want k=%0d s=%0d w=%0d", e.kind, e.start, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++; $display("FAIL held_pulse got k=%0d s=%0d w=%0d want k=%0d s=%0d w=%0d", o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL held_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_track();
      int k;
      pulse_t e, o;
      do_reset();
      k = cyc;
      exp_q.push_back('{kind: 1'b0, start: k + 7, width: 2});
`ifndef SR_PULSE_GEN_TRACK_EN
      exp_q.push_back('{kind: 1'b0, start: k + 37, width: 2});
`endif
      exp_q.push_back('{kind: 1'b1, start: k + 67, width: 2});
      bus.set_in = 1'b1;
      wait_cyc(10);
      bus.set_in = 1'b0;
      wait_cyc(20);
      bus.set_in = 1'b1;
      wait_cyc(10);
      bus.set_in = 1'b0;
      wait_cyc(20);
      bus.reset_in = 1'b1;
      wait_cyc(10);
      bus.reset_in = 1'b0;
      wait_cyc(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL track_pulse got none want k=%0d s=%0d w=%0d", e.kind, e.start, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++; $display("FAIL track_pulse got k=%0d s=%0d w=%0d want k=%0d s=%0d w=%0d", o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL track_extra got %0d pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      bus.set_in = 1'b0;
      bus.reset_in = 1'b0;
      test_reset();
      test_clean();
      test_bounce();
      test_both();
      test_midpulse_reset();
      test_held_through_reset();
      test_track();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_pulse_gen.md
SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a new input level (legal range 2..65535).
REQ-002 Parameter PULSE_CYCLES, default 2: width of each active-low output pulse, in clk cycles (legal range 1..255).
REQ-003 Parameter GAP_CYCLES, default 2: minimum cycles with Sbar=Rbar=1 after each pulse (legal range 1..255).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rstbar  input  1  asynchronous, active-low reset.
REQ-006 set_in  input  1  raw, asynchronous, active-high set request (push-button).
REQ-007 reset_in  input  1  raw, asynchronous, active-high reset request.
REQ-008 Sbar  output  1  active-low set pulse that drives the downstream cross-coupled NAND SR latch.
REQ-009 Rbar  output  1  active-low reset pulse that drives the same latch.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 set_in and reset_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each input SHALL have its own debouncer, built from a stable-level register and a counter.
- The counter increments while the synchronized value differs from the stable level.
- The counter clears when the two match.
- The stable level flips, and the counter clears, on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-013 A 0->1 transition of a stable level SHALL set that input's pending flag; 1->0 transitions produce no event.
REQ-014 FSM states: IDLE, SET_PULSE, RST_PULSE, GAP.
- IDLE->RST_PULSE if the reset flag is pending.
- Else IDLE->SET_PULSE if the set flag is pending.
- The pending flag is cleared on entry to the pulse state.
- *_PULSE->GAP after PULSE_CYCLES cycles.
- GAP->IDLE after GAP_CYCLES cycles.
REQ-015 Sbar SHALL be 0 only in SET_PULSE and Rbar SHALL be 0 only in RST_PULSE; both outputs are registered.
REQ-016 Sbar=0 and Rbar=0 in the same cycle SHALL never occur (forbidden latch input).
REQ-017 When both flags are pending simultaneously, reset SHALL win; the set flag stays pending and is served after GAP.
REQ-018 Events arriving while busy SHALL be held in the pending flags; a repeated event on an already-pending input SHALL be merged (flag stays 1, no count).
REQ-019 Latency: with an uninterrupted high input in IDLE, Sbar (or Rbar) SHALL first read 0 exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples the input high.
REQ-020 Bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no pulse.
REQ-021 Pulse and gap counters SHALL be sized by $clog2 of their parameter and never wrap.

Reset
REQ-022 While rstbar=0, the following SHALL hold asynchronously:
- Sbar=1, Rbar=1, busy=0, FSM=IDLE;
- synchronizers, stable levels, counters and pending flags at 0.
REQ-023 Reset asserted mid-pulse SHALL immediately return both outputs to 1 and discard all pending events.
REQ-024 After reset release, an input already high SHALL be debounced as a fresh 0->1 event.

Configuration
REQ-025 Macro SR_PULSE_GEN_TRACK_EN: when defined, the block SHALL do both of the following:
- keep an internal q_track register, reset to 0, set on SET_PULSE entry and cleared on RST_PULSE entry;
- discard (clear without pulsing) a pending event that matches q_track.
REQ-026 When SR_PULSE_GEN_TRACK_EN is undefined, every accepted event SHALL pulse and no q_track logic SHALL exist.

Structure
REQ-027 Package sr_pulse_gen_pkg SHALL hold the FSM state enum typedef and the default-parameter constants.
REQ-028 One sub-module, sr_debounce (synchronizer, counter and stable level, one input), SHALL be instantiated twice.

Verification
All scenarios use DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, GAP_CYCLES=2.
REQ-029 Clean set press: set_in 0->1 and held -> Sbar=0 for exactly 2 cycles, starting 6 edges after the first sampling edge; Rbar stays 1.
REQ-030 Bounce: set_in toggles 1,1,1,0 repeatedly for 40 cycles -> no pulse on either output.
REQ-031 Both inputs rise on the same cycle -> Rbar=0 for 2 cycles, then 2 cycles of 1/1, then Sbar=0 for 2 cycles; overlap checker reports zero conflicts.
REQ-032 rstbar driven low in the second Sbar=0 cycle -> Sbar=1 that same cycle; no later pulse until a new input rise.
REQ-033 With SR_PULSE_GEN_TRACK_EN: two set presses 30 cycles apart -> only the first produces Sbar=0; a following reset press produces Rbar=0.
REQ-034 Without SR_PULSE_GEN_TRACK_EN: the same stimulus -> two Sbar pulses and one Rbar pulse.
